// File: rtl/serial_adder_n.sv
// Bit-serial adder: WIDTH-bit operands summed LSB-first through one full-adder cell and a carry flop.
// Latency: start sampled at E0 -> done pulse in the cycle after E_WIDTH (WIDTH+1 edges); one op per WIDTH+1 cycles.
// Backpressure: none; start is ignored while busy, accepted in IDLE or in the DONE cycle (back-to-back).
// Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN (adds port sub; a-b-cin, cout=1 means no borrow).
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must hold WIDTH-1 without wrapping, including the WIDTH=1 case.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_work;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_work_nxt;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    // Subtract is add of the inverted operand with the carry-in flipped (two's complement).
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = cin ^ sub;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    // A new request is only taken when no operation is in flight.
    assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last      = (r_cnt == LAST_BIT);

    // The single full-adder cell.
    assign w_bit       = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_carry_nxt = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));

    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_work_w1
            assign w_work_nxt = w_bit;
        end else begin : g_work_wn
            assign w_work_nxt = {w_bit, r_work[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; busy/done decode directly from the state.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = w_accept ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting, and result capture on the final bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_carry <= w_carry_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_work_nxt;
                r_cout <= w_carry_nxt;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised bit-serial adder: WIDTH-bit operands are added LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Start/done handshake; result and carry-out are registered and held until the next completion.
- Successor to the single-bit serial adder cell; used wherever area matters more than latency, e.g. accumulators and checksum paths.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  initial carry; captured on the accepted start edge.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  registered result; held until the next completion.
- cout  out  1  registered final carry; held with sum.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - shift registers, carry flip-flop and bit counter are cleared.
- State machine: IDLE, RUN, DONE.
  - IDLE: on start=1 at edge E0, load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0; go to RUN.
  - RUN, each edge:
    - bit = a_sh[0]^b_sh[0]^carry.
    - carry <= (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])).
    - a_sh and b_sh shift right by one.
    - Working register shifts right with bit entering at the MSB.
    - cnt increments.
  - RUN exit: on the edge processing bit WIDTH-1 (edge E_WIDTH), load sum<=final working value and cout<=final carry, then go to DONE.
  - DONE: lasts exactly one cycle with done=1.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back); next state is RUN.
    - Otherwise next state is IDLE.
- Latency: start sampled at E0 gives done=1 in the cycle after E_WIDTH, i.e. WIDTH+1 edges from request to result. Throughput is one operation per WIDTH+1 cycles.
- busy=1 exactly in RUN, for WIDTH cycles.
- start while in RUN is ignored; operands and cin are not re-sampled.
- sum and cout change only at the RUN→DONE edge or on reset. The previous result stays visible during a new operation.
- WIDTH=1: RUN lasts one cycle. The counter must not wrap incorrectly; counter width is $clog2(WIDTH+1).
- Reset mid-RUN aborts the operation; no done pulse is produced and outputs return to 0.
- Arithmetic is modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands on the accepted start edge.
  - sub=1 loads b_sh<=~b and carry<=cin^1, computing a-b-cin. cout=1 means no borrow; cout=0 means borrow.
  - sub=0 gives identical behaviour to the add-only build.
- Undefined: no sub port; add-only.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset with clk running → sum=0x00, cout=0, busy=0, done=0. Assert reset mid-RUN at the 4th bit edge → same values, no done pulse; a following start works normally.
- WIDTH=8, a=0x3C, b=0x05, cin=0, start at E0 → busy high for 8 cycles, done pulse after E8, sum=0x41, cout=0.
- a=0xFF, b=0x01, cin=1 → sum=0x01, cout=1. Previous sum=0x41 stays visible during RUN.
- Hold start high with a=0xAA, b=0x55 throughout RUN of an op with a=0x01, b=0x01 → result 0x02. Start is re-accepted in the DONE cycle: the next op yields 0xFF after a further 9 edges with no IDLE gap.
- WIDTH=1: a=1, b=1, cin=1 → done after 2 edges, sum=1, cout=1.
- With SERIAL_ADDER_SUB_EN, WIDTH=8, sub=1, cin=0:
  - a=0x20, b=0x10 → sum=0x10, cout=1.
  - a=0x10, b=0x20 → sum=0xF0, cout=0.
